// File: rtl/axi_stream_pkg.sv
// Shared definitions for the AXI4-Stream protocol checker.
// Holds the error bit indices, the packet FSM states and small helper functions.
package axi_stream_pkg;

    localparam int ERR_VALID_DROP       = 0;
    localparam int ERR_PAYLOAD_UNSTABLE = 1;
    localparam int ERR_STRB_NO_KEEP     = 2;
    localparam int ERR_RESET_VALID      = 3;
    localparam int ERR_PKT_TOO_LONG     = 4;
    localparam int ERR_STALL_TIMEOUT    = 5;
    localparam int ERR_COUNT            = 6;
    localparam logic [2:0] ERR_NONE     = 3'd7;

    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_IN   = 1'b1
    } pkt_state_t;

    // Ceiling log2, never below 1 so it can size a counter directly.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [2:0] lowest_err(input logic [ERR_COUNT-1:0] bits);
        logic [2:0] idx;
        idx = ERR_NONE;
        for (int i = ERR_COUNT - 1; i >= 0; i--) begin
            if (bits[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_stream_payload_history.sv
// One-cycle history of the tapped stream: previous valid, previous handshake
// and a payload snapshot, plus the combinational "payload changed" compare.
module axi_stream_payload_history #(
    parameter int byte_width = 4,
    parameter int id_width   = 0,
    parameter int dest_width = 0,
    parameter int user_width = 0
) (
    input  logic                                       clk,
    input  logic                                       resetn,
    input  logic                                       tvalid,
    input  logic                                       hs,
    input  logic [8*byte_width-1:0]                    tdata,
    input  logic [byte_width-1:0]                      tstrb,
    input  logic [byte_width-1:0]                      tkeep,
    input  logic                                       tlast,
    input  logic [(id_width   > 0 ? id_width   : 1)-1:0] tid,
    input  logic [(dest_width > 0 ? dest_width : 1)-1:0] tdest,
    input  logic [(user_width > 0 ? user_width : 1)-1:0] tuser,
    output logic                                       prev_tvalid,
    output logic                                       prev_hs,
    output logic                                       payload_changed
);

    localparam int BASE_W = 10 * byte_width + 1;

    logic [BASE_W-1:0] w_base;
    logic [BASE_W-1:0] r_prev_base;
    logic              r_prev_tvalid;
    logic              r_prev_hs;
    logic              w_id_changed;
    logic              w_dest_changed;
    logic              w_user_changed;

    assign w_base = {tdata, tstrb, tkeep, tlast};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prev_tvalid <= 1'b0;
            r_prev_hs     <= 1'b0;
            r_prev_base   <= '0;
        end else begin
            r_prev_tvalid <= tvalid;
            r_prev_hs     <= hs;
            r_prev_base   <= w_base;
        end
    end

    // Absent sideband fields contribute nothing to the stability compare.
    generate
        if (id_width > 0) begin : g_id
            logic [id_width-1:0] r_prev_tid;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) r_prev_tid <= '0;
                else         r_prev_tid <= tid;
            end
            assign w_id_changed = (tid != r_prev_tid);
        end else begin : g_no_id
            logic w_unused_id;
            assign w_unused_id  = ^tid;
            assign w_id_changed = 1'b0;
        end

        if (dest_width > 0) begin : g_dest
            logic [dest_width-1:0] r_prev_tdest;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) r_prev_tdest <= '0;
                else         r_prev_tdest <= tdest;
            end
            assign w_dest_changed = (tdest != r_prev_tdest);
        end else begin : g_no_dest
            logic w_unused_dest;
            assign w_unused_dest  = ^tdest;
            assign w_dest_changed = 1'b0;
        end

        if (user_width > 0) begin : g_user
            logic [user_width-1:0] r_prev_tuser;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) r_prev_tuser <= '0;
                else         r_prev_tuser <= tuser;
            end
            assign w_user_changed = (tuser != r_prev_tuser);
        end else begin : g_no_user
            logic w_unused_user;
            assign w_unused_user  = ^tuser;
            assign w_user_changed = 1'b0;
        end
    endgenerate

    assign prev_tvalid     = r_prev_tvalid;
    assign prev_hs         = r_prev_hs;
    assign payload_changed = (w_base != r_prev_base) | w_id_changed | w_dest_changed | w_user_changed;

endmodule

// File: rtl/axi_stream_protocol_checker.sv
// Passive AXI4-Stream protocol checker: sticky error flags, first-error index,
// packet tracking and beat/packet traffic counters for a status register block.
module axi_stream_protocol_checker
    import axi_stream_pkg::*;
#(
    parameter int byte_width       = 4,
    parameter int id_width         = 0,
    parameter int dest_width       = 0,
    parameter int user_width       = 0,
    parameter int has_tready       = 1,
    parameter int has_tlast        = 1,
    parameter int max_packet_beats = 256,
    parameter int stall_limit      = 1024,
    parameter int count_width      = 32
) (
    input  logic                                       clk,
    input  logic                                       resetn,
    input  logic                                       tvalid,
    input  logic                                       tready,
    input  logic [8*byte_width-1:0]                    tdata,
    input  logic [byte_width-1:0]                      tstrb,
    input  logic [byte_width-1:0]                      tkeep,
    input  logic                                       tlast,
    input  logic [(id_width   > 0 ? id_width   : 1)-1:0] tid,
    input  logic [(dest_width > 0 ? dest_width : 1)-1:0] tdest,
    input  logic [(user_width > 0 ? user_width : 1)-1:0] tuser,
    input  logic                                       err_clear,
    output logic [5:0]                                 err_flags,
    output logic [2:0]                                 err_first,
    output logic                                       in_packet,
    output logic [count_width-1:0]                     beat_count,
    output logic [count_width-1:0]                     packet_count
);

    localparam int PB_W    = clog2(max_packet_beats + 2);
    localparam int STALL_W = clog2(stall_limit + 1);
    localparam logic [PB_W-1:0]    PKT_MAX    = PB_W'(max_packet_beats);
    localparam logic [PB_W-1:0]    PKT_SAT    = PB_W'(max_packet_beats + 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(stall_limit);
    localparam logic [STALL_W-1:0] STALL_TRIG = STALL_W'(stall_limit - 1);

    logic                    w_tready_eff;
    logic                    w_tlast_eff;
    logic                    w_hs;
    logic                    w_stall;
    logic                    w_prev_tvalid;
    logic                    w_prev_hs;
    logic                    w_payload_changed;
    logic [ERR_COUNT-1:0]    w_new_err;
    pkt_state_t              r_state;
    pkt_state_t              w_state_next;
    logic                    r_first_cycle;
    logic [STALL_W-1:0]      r_stall_cnt;
    logic [PB_W-1:0]         r_pkt_beats;
    logic [ERR_COUNT-1:0]    r_err_flags;
    logic [2:0]              r_err_first;
    logic [count_width-1:0]  r_beat_count;
    logic [count_width-1:0]  r_packet_count;

    assign w_tready_eff = (has_tready != 0) ? tready : 1'b1;
    assign w_tlast_eff  = (has_tlast  != 0) ? tlast  : 1'b1;
    assign w_hs         = tvalid && w_tready_eff;
    assign w_stall      = tvalid && !w_tready_eff;

    axi_stream_payload_history #(
        .byte_width (byte_width),
        .id_width   (id_width),
        .dest_width (dest_width),
        .user_width (user_width)
    ) u_history (
        .clk             (clk),
        .resetn          (resetn),
        .tvalid          (tvalid),
        .hs              (w_hs),
        .tdata           (tdata),
        .tstrb           (tstrb),
        .tkeep           (tkeep),
        .tlast           (tlast),
        .tid             (tid),
        .tdest           (tdest),
        .tuser           (tuser),
        .prev_tvalid     (w_prev_tvalid),
        .prev_hs         (w_prev_hs),
        .payload_changed (w_payload_changed)
    );

    always_comb begin
        w_new_err = '0;
        w_new_err[ERR_VALID_DROP]       = w_prev_tvalid && !w_prev_hs && !tvalid;
        w_new_err[ERR_PAYLOAD_UNSTABLE] = w_prev_tvalid && !w_prev_hs && tvalid && w_payload_changed;
        w_new_err[ERR_STRB_NO_KEEP]     = tvalid && |(tstrb & ~tkeep);
        w_new_err[ERR_RESET_VALID]      = r_first_cycle && tvalid;
        w_new_err[ERR_PKT_TOO_LONG]     = (has_tlast != 0) && w_hs && (r_pkt_beats == PKT_MAX);
        w_new_err[ERR_STALL_TIMEOUT]    = (stall_limit != 0) && w_stall && (r_stall_cnt == STALL_TRIG);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PKT_IDLE: if (w_hs && !w_tlast_eff) w_state_next = PKT_IN;
            PKT_IN:   if (w_hs &&  w_tlast_eff) w_state_next = PKT_IDLE;
            default:  w_state_next = PKT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= PKT_IDLE;
            r_first_cycle  <= 1'b1;
            r_stall_cnt    <= '0;
            r_pkt_beats    <= '0;
            r_err_flags    <= '0;
            r_err_first    <= ERR_NONE;
            r_beat_count   <= '0;
            r_packet_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_first_cycle <= 1'b0;

            // Saturating, so a single long stall raises the timeout only once.
            if (stall_limit == 0 || !w_stall) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != STALL_MAX) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (w_hs) begin
                if (w_tlast_eff)              r_pkt_beats <= '0;
                else if (r_pkt_beats != PKT_SAT) r_pkt_beats <= r_pkt_beats + 1'b1;
            end

            // A clear coinciding with a fresh violation keeps only the fresh bits.
            if (err_clear) begin
                r_err_flags <= w_new_err;
                r_err_first <= lowest_err(w_new_err);
            end else begin
                r_err_flags <= r_err_flags | w_new_err;
                if (r_err_first == ERR_NONE && |w_new_err) r_err_first <= lowest_err(w_new_err);
            end

            if (w_hs)                r_beat_count   <= r_beat_count + 1'b1;
            if (w_hs && w_tlast_eff) r_packet_count <= r_packet_count + 1'b1;
        end
    end

    assign err_flags    = r_err_flags;
    assign err_first    = r_err_first;
    assign in_packet    = (r_state == PKT_IN);
    assign beat_count   = r_beat_count;
    assign packet_count = r_packet_count;

endmodule

// File: tb/tb_axi_stream_protocol_checker.sv
// Directed bench for the AXI4-Stream protocol checker: instance A checks the
// error rules with tlast, instance B runs with has_tlast=0.
module tb_axi_stream_protocol_checker;

    logic        clk = 1'b0;
    logic        resetn, resetn_b;
    logic        tvalid, tready, tlast, err_clear;
    logic [31:0] tdata;
    logic [3:0]  tstrb, tkeep, tid;
    logic        tid_b, tdest, tuser;

    logic [5:0]  err_flags_a, err_flags_b;
    logic [2:0]  err_first_a, err_first_b;
    logic        in_packet_a, in_packet_b;
    logic [31:0] beat_count_a, packet_count_a;
    logic [7:0]  beat_count_b, packet_count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_stream_protocol_checker #(
        .byte_width(4), .id_width(4), .has_tready(1), .has_tlast(1),
        .max_packet_beats(4), .stall_limit(8), .count_width(32)
    ) dut_a (
        .clk(clk), .resetn(resetn), .tvalid(tvalid), .tready(tready),
        .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast),
        .tid(tid), .tdest(tdest), .tuser(tuser), .err_clear(err_clear),
        .err_flags(err_flags_a), .err_first(err_first_a), .in_packet(in_packet_a),
        .beat_count(beat_count_a), .packet_count(packet_count_a)
    );

    axi_stream_protocol_checker #(
        .byte_width(4), .has_tlast(0), .max_packet_beats(4), .count_width(8)
    ) dut_b (
        .clk(clk), .resetn(resetn_b), .tvalid(tvalid), .tready(tready),
        .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast),
        .tid(tid_b), .tdest(tdest), .tuser(tuser), .err_clear(err_clear),
        .err_flags(err_flags_b), .err_first(err_first_b), .in_packet(in_packet_b),
        .beat_count(beat_count_b), .packet_count(packet_count_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; resetn_b = 1'b0;
        tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; err_clear = 1'b0;
        tdata = '0; tstrb = 4'hF; tkeep = 4'hF; tid = '0;
        tid_b = 1'b0; tdest = 1'b0; tuser = 1'b0;
        repeat (2) tick();
        chk("rst_flags",  err_flags_a,    6'b000000);
        chk("rst_first",  err_first_a,    3'd7);
        chk("rst_inpkt",  in_packet_a,    1'b0);
        chk("rst_beats",  beat_count_a,   32'd0);
        chk("rst_pkts",   packet_count_a, 32'd0);

        // tvalid already high at the first edge after reset release
        tvalid = 1'b1; tdata = 32'hA5A5A5A5; tlast = 1'b1;
        @(negedge clk); resetn = 1'b1;
        tick();
        chk("rstv_flags", err_flags_a,    6'b001000);
        chk("rstv_first", err_first_a,    3'd3);
        chk("rstv_beats", beat_count_a,   32'd0);
        chk("rstv_pkts",  packet_count_a, 32'd0);

        err_clear = 1'b1; tick();
        chk("clr_flags",  err_flags_a, 6'b000000);
        chk("clr_first",  err_first_a, 3'd7);
        err_clear = 1'b0; tick();

        // data changes during the stall, then valid drops
        tdata = 32'h0; tick();
        chk("unst_flags", err_flags_a, 6'b000010);
        chk("unst_first", err_first_a, 3'd1);
        tvalid = 1'b0; tick();
        chk("drop_flags", err_flags_a, 6'b000011);
        chk("drop_first", err_first_a, 3'd1);

        // strobe without keep, coinciding with err_clear
        tvalid = 1'b1; tready = 1'b1; tkeep = 4'b0011; tstrb = 4'b0100; err_clear = 1'b1;
        tick();
        chk("strb_flags", err_flags_a,    6'b000100);
        chk("strb_first", err_first_a,    3'd2);
        chk("strb_beats", beat_count_a,   32'd1);
        chk("strb_pkts",  packet_count_a, 32'd1);
        tvalid = 1'b0; tkeep = 4'hF; tstrb = 4'hF; tick();
        chk("clr2_flags", err_flags_a, 6'b000000);
        chk("clr2_first", err_first_a, 3'd7);
        err_clear = 1'b0;

        // 5-beat packet (one beat too many), then a legal 4-beat packet
        tvalid = 1'b1; tready = 1'b1;
        for (int b = 1; b <= 5; b++) begin
            tdata = 32'(b); tlast = (b == 5); tick();
            if (b == 4) begin
                chk("p5_inpkt",  in_packet_a, 1'b1);
                chk("p5_flags4", err_flags_a, 6'b000000);
            end
        end
        chk("long_flags", err_flags_a, 6'b010000);
        chk("long_first", err_first_a, 3'd4);
        chk("long_inpkt", in_packet_a, 1'b0);
        for (int b = 1; b <= 4; b++) begin
            tdata = 32'(b + 16); tlast = (b == 4); tick();
            if (b == 2) chk("p4_inpkt", in_packet_a, 1'b1);
        end
        chk("p4_flags",   err_flags_a,    6'b010000);
        chk("p4_pkts",    packet_count_a, 32'd3);
        chk("p4_beats",   beat_count_a,   32'd10);
        chk("p4_inpkt_e", in_packet_a,    1'b0);
        tvalid = 1'b0; err_clear = 1'b1; tick(); err_clear = 1'b0;

        // 8-cycle stall reaches the limit
        tvalid = 1'b1; tready = 1'b0; tlast = 1'b1; tdata = 32'h12345678;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 7) chk("stall7_flags", err_flags_a, 6'b000000);
        end
        chk("stall_flags", err_flags_a, 6'b100000);
        chk("stall_first", err_first_a, 3'd5);
        tick(); tick();
        chk("stall_hold", err_flags_a, 6'b100000);
        tready = 1'b1; tick();
        chk("stall_beats", beat_count_a,   32'd11);
        chk("stall_pkts",  packet_count_a, 32'd4);
        tvalid = 1'b0; tready = 1'b0; err_clear = 1'b1; tick(); err_clear = 1'b0;

        // 7-cycle stall then handshake: no timeout
        tvalid = 1'b1;
        repeat (7) tick();
        tready = 1'b1; tick();
        chk("s7_flags", err_flags_a,    6'b000000);
        chk("s7_first", err_first_a,    3'd7);
        chk("s7_beats", beat_count_a,   32'd12);
        chk("s7_pkts",  packet_count_a, 32'd5);
        tvalid = 1'b0; tick();
        chk("s7_drop_ok", err_flags_a, 6'b000000);

        // TID change while stalled
        tvalid = 1'b1; tready = 1'b0; tid = 4'd3; tick();
        tid = 4'd5; tick();
        chk("tid_flags", err_flags_a, 6'b000010);
        chk("tid_first", err_first_a, 3'd1);
        tready = 1'b1; tick();
        tvalid = 1'b0; tready = 1'b0; err_clear = 1'b1; tick(); err_clear = 1'b0;

        // has_tlast=0 instance: every beat is a packet
        tlast = 1'b0;
        @(negedge clk); resetn_b = 1'b1;
        tick();
        chk("b_rst_pkts", packet_count_b, 8'd0);
        tvalid = 1'b1; tready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tdata = 32'(i * 3); tick();
            chk("b_inpkt", in_packet_b,    1'b0);
            chk("b_bit4",  err_flags_b[4], 1'b0);
        end
        tvalid = 1'b0; tick();
        chk("b_pkts",  packet_count_b, 8'd10);
        chk("b_beats", beat_count_b,   8'd10);
        chk("b_flags", err_flags_b,    6'b000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
